// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: imem request/response, decode handshake and redirect signals of the fetch queue.
interface inst_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    input  imem_gnt, imem_rsp_valid, imem_rsp_inst, dec_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc,
    output imem_gnt, imem_rsp_valid, imem_rsp_inst, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: owns the fetch PC, issues in-order imem requests and queues {inst, pc} for decode.
module inst_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic                clk,
  input logic                rstn,
  inst_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
  logic [31:0]   fetch_pc, rsp_pc, jump_pc;
  logic [CW-1:0] count, outst, drop, outst_rd;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q [DEPTH];
  logic          run, fire, push, pop;
  // run keeps imem_req low while in reset and until the first clock after release
  always_comb begin
    bus.imem_req  = run && !bus.redirect_valid && ({1'b0, count} + {1'b0, outst} < DEPTH_C) && (outst < MAX_C);
    bus.imem_addr = fetch_pc;
    bus.dec_valid = count != '0;
    bus.dec_inst  = count != '0 ? inst_q[rd_ptr] : 32'h0000_0013;
    bus.dec_pc    = count != '0 ? pc_q[rd_ptr] : 32'h0;
    fire          = bus.imem_req && bus.imem_gnt;
    push          = bus.imem_rsp_valid && drop == '0 && !bus.redirect_valid;
    pop           = count != '0 && bus.dec_ready && !bus.redirect_valid;
    jump_pc       = {bus.redirect_pc[31:2], 2'b00};
    outst_rd      = outst - CW'(bus.imem_rsp_valid);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      run      <= 1'b1;
      fetch_pc <= jump_pc;
      rsp_pc   <= jump_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      outst    <= outst_rd;
      drop     <= outst_rd;
    end else begin
      run   <= 1'b1;
      outst <= outst_rd + CW'(fire);
      count <= count + CW'(push) - CW'(pop);
      if (fire) fetch_pc <= fetch_pc + 32'd4;
      if (push) rsp_pc <= rsp_pc + 32'd4;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (bus.imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
    end
  always_ff @(posedge clk)
    if (push) begin
      inst_q[wr_ptr] <= bus.imem_rsp_inst;
      pc_q[wr_ptr]   <= rsp_pc;
    end
  // request credits guarantee a free slot for every accepted response
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: randomized scoreboard bench; the reference tags each request with a
// redirect epoch and delivers only current-epoch responses to an expected decode queue.
module tb_inst_fetch_queue;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  typedef struct { logic [31:0] pc; logic [31:0] inst; int ep; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  inst_fetch_queue_if bus();
  inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  int total = 0;
  int passed = 0;
  ent_t sb[$];
  req_t inflight[$];
  int lat = 1, gnt_pct = 100, rsp_pct = 100, rdy_pct = 100, rdr_pct = 0;
  int epoch = 0, cyc = 0;
  logic [31:0] m_pc = RESET_PC;
  logic a_fire = 1'b0, a_rsp = 1'b0, a_rdr = 1'b0;
  logic [31:0] a_rpc = 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask
  task automatic drive_idle();
    bus.imem_gnt       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_inst  = 32'h0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    a_fire = 1'b0;
    a_rsp  = 1'b0;
    a_rdr  = 1'b0;
  endtask
  // one cycle: account for what the last edge did, then drive and check the next cycle
  task automatic step(input logic frd, input logic [31:0] fpc);
    logic exp_req;
    @(posedge clk);
    #1;
    cyc++;
    if (a_rsp) begin
      if (inflight[0].ep == epoch && !a_rdr) sb.push_back('{inflight[0].pc, inflight[0].inst});
      inflight.delete(0);
    end
    if (a_rdr) begin
      sb.delete();
      epoch++;
      m_pc = {a_rpc[31:2], 2'b00};
    end
    if (a_fire) begin
      inflight.push_back('{m_pc, $urandom, epoch, cyc + lat - 1});
      m_pc += 32'd4;
    end
    bus.redirect_valid = frd || ($urandom_range(99) < rdr_pct);
    bus.redirect_pc    = frd ? fpc : $urandom;
    bus.dec_ready      = $urandom_range(99) < rdy_pct;
    a_rsp = inflight.size() != 0 && inflight[0].due <= cyc && $urandom_range(99) < rsp_pct;
    bus.imem_rsp_valid = a_rsp;
    bus.imem_rsp_inst  = a_rsp ? inflight[0].inst : $urandom;
    bus.imem_gnt       = $urandom_range(99) < gnt_pct;
    a_rdr = bus.redirect_valid;
    a_rpc = bus.redirect_pc;
    exp_req = !a_rdr && (sb.size() + inflight.size() < DEPTH) && (inflight.size() < MAX_OUTST);
    #1;
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    a_fire = exp_req && bus.imem_gnt;
  endtask
  task automatic mid_reset();
    #1 rstn = 1'b0;
    #1;
    chk("reset dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("reset imem_req", 32'(bus.imem_req), 32'h0);
    chk("reset dec_inst", bus.dec_inst, NOP);
    chk("reset dec_pc", bus.dec_pc, 32'h0);
    sb.delete();
    inflight.delete();
    m_pc = RESET_PC;
    epoch++;
    drive_idle();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    #1 chk("post-reset imem_addr", bus.imem_addr, RESET_PC);
  endtask
  always @(negedge clk)
    if (rstn) begin
      chk("dec_valid", 32'(bus.dec_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("dec_inst", bus.dec_inst, sb[0].inst);
        chk("dec_pc", bus.dec_pc, sb[0].pc);
        if (bus.dec_ready && !bus.redirect_valid) sb.delete(0);
      end else begin
        chk("idle dec_inst", bus.dec_inst, NOP);
        chk("idle dec_pc", bus.dec_pc, 32'h0);
      end
    end
  initial begin
    drive_idle();
    #1;
    chk("reset imem_req", 32'(bus.imem_req), 32'h0);
    chk("reset dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("reset dec_inst", bus.dec_inst, NOP);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    #1 chk("post-reset imem_addr", bus.imem_addr, RESET_PC);
    repeat (40) step(1'b0, 32'h0);
    rdy_pct = 0;
    repeat (20) step(1'b0, 32'h0);
    rdy_pct = 100;
    repeat (10) step(1'b0, 32'h0);
    lat = 3;
    repeat (6) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    repeat (20) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0203);
    repeat (6) step(1'b0, 32'h0);
    lat = 1;
    step(1'b1, 32'hFFFF_FFF6);
    repeat (10) step(1'b0, 32'h0);
    gnt_pct = 70;
    rsp_pct = 75;
    rdy_pct = 60;
    rdr_pct = 6;
    for (int i = 0; i < 700; i++) begin
      lat = $urandom_range(1, 4);
      step(1'b0, 32'h0);
    end
    rdr_pct = 0;
    rdy_pct = 0;
    gnt_pct = 100;
    rsp_pct = 100;
    lat = 2;
    repeat (5) step(1'b0, 32'h0);
    mid_reset();
    rdy_pct = 100;
    repeat (30) step(1'b0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
